// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing and test-pattern source with run/drain control.
module video_timing_gen #(
  parameter int H_WIDTH  = 1920,
  parameter int H_START  = 2008,
  parameter int H_SYNC   = 44,
  parameter int H_TOTAL  = 2200,
  parameter int V_HEIGHT = 1080,
  parameter int V_START  = 1084,
  parameter int V_SYNC   = 5,
  parameter int V_TOTAL  = 1125,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int KH       = 30,
  parameter int KV       = 30
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic [1:0]                 pat_i,
  output logic                       hs_o,
  output logic                       vs_o,
  output logic                       de_o,
  output logic [23:0]                data_o,
  output logic [$clog2(H_TOTAL)-1:0] hcnt_o,
  output logic [$clog2(V_TOTAL)-1:0] vcnt_o,
  output logic                       sof_o
);
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int KHW = $clog2(KH + 1);
  localparam int KVW = $clog2(KV + 1);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_WIDTH);
  localparam logic [HW-1:0] H_SBEG  = HW'(H_START);
  localparam logic [HW-1:0] H_SEND  = HW'(H_START + H_SYNC - 1);
  localparam logic [HW-1:0] BAR_L   = HW'(H_WIDTH / 8 - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_HEIGHT);
  localparam logic [VW-1:0] V_SBEG  = VW'(V_START);
  localparam logic [VW-1:0] V_SEND  = VW'(V_START + V_SYNC - 1);
  localparam logic [KHW-1:0] KH_L   = KHW'(KH - 1);
  localparam logic [KVW-1:0] KV_L   = KVW'(KV - 1);
  localparam logic [7:0][23:0] BARS = {24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
                                       24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF};
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [HW-1:0]  h, bcnt;
  logic [VW-1:0]  v;
  logic [2:0]     bidx;
  logic [KHW-1:0] kh;
  logic [KVW-1:0] kv;
  logic           cpar, rpar;
  logic [1:0]     pat_q, pat_c;
  logic           run, h_wrap, v_wrap, origin, de_c, hs_c, vs_c;
  logic [7:0]     h8;
  logic [23:0]    pix;
  assign run    = state != IDLE;
  assign h_wrap = h == H_LAST;
  assign v_wrap = v == V_LAST;
  assign origin = h == '0 && v == '0;
  assign h8     = 8'(h);
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  // Drain only ends on the frame wrap, so a stop never truncates a frame.
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (en_i ? RUN : IDLE)
            : en_i ? RUN
            : (state == DRAIN && h_wrap && v_wrap) ? IDLE : DRAIN;
  end
  always_comb begin
    pat_c = pat_q;
    pat_c = (origin && (state == RUN || state_n == RUN)) ? pat_i : pat_q;
    de_c  = h < H_ACT && v < V_ACT;
    hs_c  = h >= H_SBEG && h <= H_SEND;
    vs_c  = v >= V_SBEG && v <= V_SEND;
    pix   = pat_c == 2'd0 ? BARS[bidx]
          : pat_c == 2'd1 ? {h8, h8, h8}
          : pat_c == 2'd2 ? {24{cpar == rpar}} : 24'h0;
  end
  always_ff @(posedge clk_i)
    if (rst_i || !run) begin
      h    <= '0;
      v    <= '0;
      bcnt <= '0;
      bidx <= '0;
      kh   <= '0;
      kv   <= '0;
      cpar <= 1'b0;
      rpar <= 1'b0;
    end else begin
      h <= h_wrap ? '0 : h + 1'b1;
      if (h_wrap) v <= v_wrap ? '0 : v + 1'b1;
      bcnt <= (h_wrap || bcnt == BAR_L) ? '0 : bcnt + 1'b1;
      if (h_wrap) bidx <= '0;
      else if (bcnt == BAR_L && bidx != 3'd7) bidx <= bidx + 1'b1;
      kh   <= (h_wrap || kh == KH_L) ? '0 : kh + 1'b1;
      cpar <= h_wrap ? 1'b0 : (kh == KH_L) ^ cpar;
      if (h_wrap) begin
        kv   <= (v_wrap || kv == KV_L) ? '0 : kv + 1'b1;
        rpar <= v_wrap ? 1'b0 : (kv == KV_L) ^ rpar;
      end
    end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      pat_q  <= 2'd0;
      hs_o   <= !HS_POL;
      vs_o   <= !VS_POL;
      de_o   <= 1'b0;
      data_o <= 24'h0;
      hcnt_o <= '0;
      vcnt_o <= '0;
      sof_o  <= 1'b0;
    end else begin
      pat_q  <= pat_c;
      hs_o   <= (run && hs_c) ? HS_POL : !HS_POL;
      vs_o   <= (run && vs_c) ? VS_POL : !VS_POL;
      de_o   <= run && de_c;
      data_o <= (run && de_c) ? pix : 24'h0;
      hcnt_o <= run ? h : '0;
      vcnt_o <= run ? v : '0;
      sof_o  <= run && origin;
    end
endmodule
